compression_stream_arbiter: RTL and testbench
=============================================

// Module: compression_stream_arbiter
// PURPOSE
//  Shares the single streaming gzip compressor between N_STREAMS host input streams.
//  Grants the compressor one whole frame at a time, up to tlast, in round-robin order.
//  Records each granted stream ID in an in-order tag FIFO and tags the compressed
//  output frames with that ID (tid) before they go to the host send stream.
//  Sits between the host recv streams and the input FIFO/compressor; output faces host send.
// PARAMETERS
//  N_STREAMS  4    number of requesting input streams (2..16)
//  DATA_W     512  input/compressor-input data width, bits
//  OUT_W      64   compressor output data width, bits
//  ID_W       4    tid width; must satisfy 2**ID_W >= N_STREAMS
//  TAG_DEPTH  16   frames in flight (granted, output tlast not yet sent); power of 2
// PORTS
//  clk        in   1              single clock, all logic
//  rst        in   1              asynchronous reset, active-high
//  s_tdata    in   N*DATA_W       input stream i data, slice [i*DATA_W +: DATA_W]
//  s_tkeep    in   N*DATA_W/8     input byte enables, sliced likewise
//  s_tlast    in   N              input end-of-frame per stream
//  s_tvalid   in   N              input valid per stream
//  s_tready   out  N              input ready per stream
//  c_tdata    out  DATA_W         to compressor: data of the granted stream
//  c_tkeep    out  DATA_W/8       to compressor: byte enables
//  c_tlast    out  1              to compressor: end of frame
//  c_tvalid   out  1              to compressor: valid
//  c_tready   in   1              from compressor: ready
//  r_tdata    in   OUT_W          compressed data from compressor
//  r_tkeep    in   OUT_W/8        compressed byte enables
//  r_tlast    in   1              end of compressed frame
//  r_tvalid   in   1              compressed valid
//  r_tready   out  1              ready to compressor output
//  m_tdata    out  OUT_W          to host send: data (pass-through of r_tdata)
//  m_tkeep    out  OUT_W/8        to host send: byte enables
//  m_tlast    out  1              to host send: end of frame
//  m_tid      out  ID_W           to host send: source stream ID of the current frame
//  m_tvalid   out  1              to host send: valid
//  m_tready   in   1              from host send: ready
//  tags_full  out  1              status: tag FIFO holds TAG_DEPTH entries
// BEHAVIOUR
//  Reset (async, while rst=1): state IDLE, rr_ptr=N_STREAMS-1 (stream 0 wins first),
//   tag FIFO empty; s_tready=0, c_tvalid=0, r_tready=0, m_tvalid=0, m_tid=0, tags_full=0.
//  Contract: the compressor emits exactly one output frame (one r_tlast) per input
//   frame, in input order. The compressor is reset by the same rst.
//  Input FSM, registered grant g:
//   IDLE: if any s_tvalid and tag FIFO not full -> choose first i with s_tvalid[i] from
//     rr_ptr+1 upward, wrapping mod N; latch g=i; push i into tag FIFO this cycle;
//     go to XFER next cycle. Else stay. All s_tready=0, c_tvalid=0 in IDLE.
//   XFER: c_* = s_*[g]; c_tvalid=s_tvalid[g]; s_tready[g]=c_tready; others 0.
//     Beat transfers on s_tvalid[g]&c_tready. On a beat with s_tlast[g]=1:
//     rr_ptr<=g, go to IDLE. Costs one idle cycle per frame; no mid-frame switch.
//  Tag FIFO: push in the IDLE grant cycle; pop on m_tvalid&m_tready&m_tlast.
//   Simultaneous push+pop allowed, count unchanged. Full is evaluated on the
//   registered count; a pop in the same cycle does not unblock a grant.
//   tags_full=(count==TAG_DEPTH), registered.
//  Output path, combinational: m_tdata/m_tkeep/m_tlast = r_*; m_tid = FIFO head;
//   m_tvalid = r_tvalid & !tag_empty; r_tready = m_tready & !tag_empty. Latency 0 cycles.
//   With the FIFO empty, compressor output is stalled, not dropped.
//  Reset mid-frame: all state is cleared immediately, partial frames and tags are
//   discarded, and arbitration restarts from stream 0.
//  Invalid or dropped s_tvalid mid-frame: hold the grant and wait; no timeout.
// TESTING
//  1 streams 0 and 2 each send one 3-beat frame at t0 -> c side carries s0 frame then
//    s2 frame (1 idle cycle between); output frames carry m_tid 0 then 2.
//  2 all 4 streams valid continuously with 2-beat frames -> grant order 0,1,2,3,0,...;
//    each m_tid matches the input order.
//  3 m_tready=0 with 1-beat frames -> 16 grants, then tags_full=1 and no further
//    s_tready; one output frame accepted -> exactly one new grant.
//  4 c_tready toggles 1/0 during an 8-beat s1 frame -> all 8 beats pass intact;
//    s_tready[0,2,3] stay 0 throughout.
//  5 r_tvalid=1 with the tag FIFO empty (forced compressor output) -> r_tready=0, m_tvalid=0.
//  6 rst pulse during beat 3 of an s3 frame -> all outputs 0 within the same cycle;
//    after release, pending s1,s3 -> s1 is granted first.

Source files
------------

// File: rtl/compression_stream_arbiter.sv
// rtl/compression_stream_arbiter.sv - round-robin whole-frame arbiter for a shared compressor
// Each granted stream ID is queued in order and tagged onto the matching compressed frame.
module compression_stream_arbiter #(
  parameter int N_STREAMS = 4,
  parameter int DATA_W    = 512,
  parameter int OUT_W     = 64,
  parameter int ID_W      = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_STREAMS*DATA_W-1:0]     s_tdata,
  input  logic [N_STREAMS*DATA_W/8-1:0]   s_tkeep,
  input  logic [N_STREAMS-1:0]            s_tlast,
  input  logic [N_STREAMS-1:0]            s_tvalid,
  output logic [N_STREAMS-1:0]            s_tready,
  output logic [DATA_W-1:0]               c_tdata,
  output logic [DATA_W/8-1:0]             c_tkeep,
  output logic                            c_tlast,
  output logic                            c_tvalid,
  input  logic                            c_tready,
  input  logic [OUT_W-1:0]                r_tdata,
  input  logic [OUT_W/8-1:0]              r_tkeep,
  input  logic                            r_tlast,
  input  logic                            r_tvalid,
  output logic                            r_tready,
  output logic [OUT_W-1:0]                m_tdata,
  output logic [OUT_W/8-1:0]              m_tkeep,
  output logic                            m_tlast,
  output logic [ID_W-1:0]                 m_tid,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            tags_full
);

  localparam int IDX_W  = $clog2(N_STREAMS);
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant, pick_idx;
  logic             pick_valid;
  int               cand;
  logic             tag_push, tag_pop, tag_empty, beat;
  logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;

  // Search starts just after the last frame's owner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= N_STREAMS; k++) begin
      cand = (int'(rr_ptr) + k) % N_STREAMS;
      if (!pick_valid && s_tvalid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tag_push  = 1'b0;
    s_tready  = '0;
    c_tvalid  = 1'b0;
    c_tlast   = 1'b0;
    beat      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid && !tags_full) begin
          tag_push  = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        c_tvalid        = s_tvalid[grant];
        c_tlast         = s_tlast[grant];
        s_tready[grant] = c_tready;
        beat            = s_tvalid[grant] & c_tready;
        if (beat && s_tlast[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign c_tdata = s_tdata[int'(grant)*DATA_W +: DATA_W];
  assign c_tkeep = s_tkeep[int'(grant)*KEEP_W +: KEEP_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDX_W'(N_STREAMS - 1);
      grant  <= '0;
    end else begin
      if (tag_push) grant <= pick_idx;
      if (beat && s_tlast[grant]) rr_ptr <= grant;
    end
  end

  assign tag_empty = (count == '0);
  assign tag_pop   = m_tvalid & m_tready & m_tlast;
  assign count_nxt = count + {{PTR_W{1'b0}}, tag_push} - {{PTR_W{1'b0}}, tag_pop};

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr] <= ID_W'(pick_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tags_full <= 1'b0;
    end else begin
      if (tag_push) wr_ptr <= wr_ptr + 1'b1;
      if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      tags_full <= (count_nxt == (PTR_W+1)'(TAG_DEPTH));
    end
  end

  // Compressor output is held off until its frame owner is known.
  assign m_tdata  = r_tdata;
  assign m_tkeep  = r_tkeep;
  assign m_tlast  = r_tlast;
  assign m_tvalid = r_tvalid & !tag_empty;
  assign r_tready = m_tready & !tag_empty;
  assign m_tid    = tag_empty ? '0 : tag_mem[rd_ptr];

endmodule

// File: tb/tb_compression_stream_arbiter.sv
// tb/tb_compression_stream_arbiter.sv - scoreboard bench for compression_stream_arbiter
// Sources and a compressor stand-in drive traffic; a monitor checks against a frame-level model.
module tb_compression_stream_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int OW  = 64;
  localparam int IW  = 4;
  localparam int TD  = 16;
  localparam int KW  = DW / 8;
  localparam int OKW = OW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]   c_tdata;
  logic [KW-1:0]   c_tkeep;
  logic            c_tlast, c_tvalid, c_tready;
  logic [OW-1:0]   r_tdata;
  logic [OKW-1:0]  r_tkeep;
  logic            r_tlast, r_tvalid, r_tready;
  logic [OW-1:0]   m_tdata;
  logic [OKW-1:0]  m_tkeep;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            m_tvalid, m_tready, tags_full;

  compression_stream_arbiter #(
    .N_STREAMS(N), .DATA_W(DW), .OUT_W(OW), .ID_W(IW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .c_tdata(c_tdata), .c_tkeep(c_tkeep), .c_tlast(c_tlast), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .r_tdata(r_tdata), .r_tkeep(r_tkeep), .r_tlast(r_tlast), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .tags_full(tags_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } in_beat_t;

  typedef struct {
    logic [OW-1:0]  data;
    logic [OKW-1:0] keep;
    logic           last;
    logic [IW-1:0]  tid;
  } out_beat_t;

  in_beat_t  src_q [N][$];
  in_beat_t  exp_c [N][$];
  int        frames_pending [N];
  bit        src_mid [N];
  out_beat_t comp_q [$];
  out_beat_t exp_m  [$];

  int  last_g    = N - 1;
  int  cur_g     = 0;
  bit  in_frame  = 1'b0;
  bit  after_last = 1'b0;
  int  cur_beats = 0;
  int  grants    = 0;
  int  m_frames  = 0;

  int  c_mode  = 0;   // 0: always ready, 1: random, 2: toggle
  int  m_mode  = 0;   // 0: hold low, 1: random, 2: one frame then low, 3: always ready
  bit  bubbles = 1'b0;
  bit  force_r = 1'b0;

  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: the next owner is the first stream after the previous owner
  // that still has an unstarted frame.
  function automatic int model_next();
    for (int k = 1; k <= N; k++) begin
      if (frames_pending[(last_g + k) % N] > 0) return (last_g + k) % N;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || exp_c[i].size() != 0 || frames_pending[i] != 0) return 1'b0;
    return comp_q.size() == 0 && exp_m.size() == 0 && !in_frame;
  endfunction

  task automatic load_frame(input int s, input int nbeats);
    in_beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data = $urandom();
      b.keep = KW'($urandom());
      b.last = (k == nbeats - 1);
      src_q[s].push_back(b);
      exp_c[s].push_back(b);
    end
    frames_pending[s]++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_c[i].delete();
      frames_pending[i] = 0;
      src_mid[i] = 1'b0;
    end
    comp_q.delete();
    exp_m.delete();
    last_g = N - 1;
    in_frame = 1'b0;
    after_last = 1'b0;
    cur_beats = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int cyc = 0;
    while (!all_idle() && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 64'(all_idle()), 64'd1);
  endtask

  // Drivers: sources, compressor stand-in and host sink; updated just after each edge.
  initial begin
    logic [N-1:0] s_fire;
    logic         r_fire, m_last_fire;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    c_tready = 1'b0;
    r_tvalid = 1'b0; r_tdata = '0; r_tkeep = '0; r_tlast = 1'b0;
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      s_fire      = s_tvalid & s_tready;
      r_fire      = r_tvalid & r_tready;
      m_last_fire = m_tvalid & m_tready & m_tlast;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst && s_fire[i] && src_q[i].size() > 0) begin
          src_mid[i] = !src_q[i][0].last;
          void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0 && (!src_mid[i] || !bubbles || $urandom_range(3) != 0)) begin
          s_tvalid[i]             = 1'b1;
          s_tdata[i*DW +: DW]     = src_q[i][0].data;
          s_tkeep[i*KW +: KW]     = src_q[i][0].keep;
          s_tlast[i]              = src_q[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
      case (c_mode)
        0:       c_tready = 1'b1;
        1:       c_tready = 1'($urandom_range(1));
        default: c_tready = ~c_tready;
      endcase
      if (!rst && r_fire && comp_q.size() > 0) void'(comp_q.pop_front());
      if (force_r) begin
        r_tvalid = 1'b1; r_tlast = 1'b1; r_tdata = 64'hdead_beef_0000_0001; r_tkeep = '1;
      end else if (comp_q.size() > 0 && $urandom_range(3) != 0) begin
        r_tvalid = 1'b1;
        r_tdata  = comp_q[0].data;
        r_tkeep  = comp_q[0].keep;
        r_tlast  = comp_q[0].last;
      end else begin
        r_tvalid = 1'b0;
        r_tlast  = 1'b0;
      end
      if (m_mode == 2 && m_last_fire && !rst) m_mode = 0;
      case (m_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'($urandom_range(1));
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every c-side and m-side transfer with the model's expectations.
  initial begin
    logic [N-1:0] oh;
    in_beat_t     eb;
    out_beat_t    ob;
    int           nb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        oh = '0;
        oh[cur_g] = 1'b1;
        if (after_last) begin
          check("idle_cycle_after_tlast", {59'd0, c_tvalid, s_tready}, 64'd0);
          after_last = 1'b0;
        end else if (in_frame) begin
          check("s_tready_other_streams", 64'(s_tready & ~oh), 64'd0);
        end
        if (c_tvalid && c_tready) begin
          if (!in_frame) begin
            cur_g = model_next();
            if (cur_g < 0) begin
              check("c_frame_expected", 64'd0, 64'd1);
              cur_g = 0;
            end else begin
              frames_pending[cur_g]--;
            end
            in_frame  = 1'b1;
            cur_beats = 0;
            oh = '0;
            oh[cur_g] = 1'b1;
          end
          check("s_tready_onehot", 64'(s_tready), 64'(oh));
          if (exp_c[cur_g].size() == 0) begin
            check("c_beat_expected", 64'd0, 64'd1);
          end else begin
            eb = exp_c[cur_g].pop_front();
            check("c_tdata", 64'(c_tdata), 64'(eb.data));
            check("c_tkeep", 64'(c_tkeep), 64'(eb.keep));
            check("c_tlast", 64'(c_tlast), 64'(eb.last));
          end
          cur_beats++;
          if (c_tlast) begin
            in_frame   = 1'b0;
            after_last = 1'b1;
            last_g     = cur_g;
            grants++;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
              ob.data = {$urandom(), $urandom()};
              ob.keep = OKW'($urandom());
              ob.last = (b == nb - 1);
              ob.tid  = IW'(cur_g);
              comp_q.push_back(ob);
              exp_m.push_back(ob);
            end
          end
        end
        if (m_tvalid && m_tready) begin
          if (exp_m.size() == 0) begin
            check("m_beat_expected", 64'd0, 64'd1);
          end else begin
            ob = exp_m.pop_front();
            check("m_tdata", m_tdata, ob.data);
            check("m_tkeep", 64'(m_tkeep), 64'(ob.keep));
            check("m_tlast", 64'(m_tlast), 64'(ob.last));
            check("m_tid", 64'(m_tid), 64'(ob.tid));
          end
          if (m_tlast) m_frames++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, mf0, cyc;
    for (int i = 0; i < N; i++) begin
      frames_pending[i] = 0;
      src_mid[i] = 1'b0;
    end
    rst = 1'b1;
    force_r = 1'b1;
    m_mode = 3;
    repeat (3) @(negedge clk);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_c_tvalid", 64'(c_tvalid), 64'd0);
    check("rst_r_tready", 64'(r_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tid", 64'(m_tid), 64'd0);
    check("rst_tags_full", 64'(tags_full), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("empty_fifo_r_tready", 64'(r_tready), 64'd0);
    check("empty_fifo_m_tvalid", 64'(m_tvalid), 64'd0);
    force_r = 1'b0;
    repeat (2) @(negedge clk);

    // Streams 0 and 2 with one 3-beat frame each.
    #2;
    load_frame(0, 3);
    load_frame(2, 3);
    wait_done("two_stream_done", 200);

    // All streams continuously valid with 2-beat frames.
    @(negedge clk); #2;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < N; s++) load_frame(s, 2);
    wait_done("all_streams_done", 400);

    // Stream 1, 8 beats, compressor ready toggling.
    c_mode = 2;
    @(negedge clk); #2;
    load_frame(1, 8);
    wait_done("toggle_ready_done", 200);

    // Randomized traffic.
    c_mode = 1; m_mode = 1; bubbles = 1'b1;
    @(negedge clk); #2;
    for (int f = 0; f < 40; f++) load_frame($urandom_range(N - 1), $urandom_range(1, 6));
    wait_done("random_done", 4000);

    // Tag FIFO full: host never ready.
    c_mode = 0; m_mode = 0; bubbles = 1'b0;
    repeat (3) @(negedge clk);
    g0 = grants;
    #2;
    for (int f = 0; f < 5; f++)
      for (int s = 0; s < N; s++) load_frame(s, 1);
    cyc = 0;
    while (grants - g0 < TD && cyc < 300) begin @(negedge clk); cyc++; end
    repeat (10) begin
      @(negedge clk);
      check("full_no_s_tready", 64'(s_tready), 64'd0);
    end
    check("full_grant_count", 64'(grants - g0), 64'(TD));
    check("tags_full_set", 64'(tags_full), 64'd1);
    mf0 = m_frames;
    m_mode = 2;
    cyc = 0;
    while (m_frames == mf0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("one_frame_released", 64'(m_frames - mf0), 64'd1);
    repeat (20) @(negedge clk);
    check("one_more_grant", 64'(grants - g0), 64'(TD + 1));
    check("tags_full_again", 64'(tags_full), 64'd1);
    m_mode = 1;
    wait_done("full_drain_done", 2000);

    // Reset during beat 3 of a stream-3 frame.
    c_mode = 0; m_mode = 3;
    @(negedge clk); #2;
    load_frame(3, 8);
    cyc = 0;
    while (!(in_frame && cur_beats == 2) && cyc < 100) begin @(negedge clk); cyc++; end
    check("reached_beat3", 64'(cur_beats), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_c_tvalid", 64'(c_tvalid), 64'd0);
    check("midrst_r_tready", 64'(r_tready), 64'd0);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_m_tid", 64'(m_tid), 64'd0);
    check("midrst_tags_full", 64'(tags_full), 64'd0);
    model_reset();
    load_frame(3, 2);
    load_frame(1, 2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done("post_reset_done", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
